scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised registered N-to-2^N one-hot decoder with an auto-scan mode. In direct mode it registers a one-hot select for the presented address. In scan mode it walks the select through every output in turn, holding each for a programmable dwell. It sits between the address/control logic and one-hot consumers such as memory bank selects and multiplexed display digit enables.

## Interface
Parameters:
- ADDR_W, 4, address width; output width is 2^ADDR_W.
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  decoder enable; 0 forces all selects inactive.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- addr  input  ADDR_W  direct-mode address; also the scan start index.
- dwell  input  DWELL_W  extra cycles each scan index is held (0 = advance every cycle).
- dec  output  2^ADDR_W  registered one-hot select, active-high.
- cur_addr  output  ADDR_W  binary index currently driven on dec.
- valid  output  1  dec carries a live select.
- wrap  output  1  one-cycle pulse when a scan wraps from the last index to index 0.

## Operation
- FSM states and their cycle behaviour:
  - OFF: dec = 0, valid = 0; cur_addr holds its last value.
  - DIRECT: each cycle, idx <= addr.
  - SCAN: dwell-counted walk through the indices.
- FSM transitions, evaluated every clock:
  - rst → OFF.
  - en = 0 → OFF.
  - en = 1, mode = 0 → DIRECT.
  - en = 1, mode = 1 → SCAN.
- Output mapping in DIRECT and SCAN:
  - dec = 1 << idx; cur_addr = idx; valid = 1.
  - dec is always exactly one-hot or all-zero. Every index 0..2^ADDR_W-1 decodes to a distinct bit.
- Entering SCAN from OFF or DIRECT:
  - idx <= addr; dwell counter cnt <= 0.
  - addr is sampled only on entry.
- In SCAN:
  - If cnt >= dwell: idx <= idx+1 modulo 2^ADDR_W, and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Each index is therefore held for dwell+1 cycles.
- dwell is read live. Lowering dwell below the current cnt advances idx on the next clock; there is no lockup.
- wrap is registered and asserted in the same cycle dec first shows index 0 after idx = 2^ADDR_W-1. It is 0 otherwise, including on SCAN entry with addr = 0.
- Switching SCAN→DIRECT: the next cycle shows onehot(addr); cnt is discarded.
- Switching DIRECT→SCAN: restart from the current addr.
- Reset mid-operation: all state and outputs cleared on the next clock edge, regardless of en/mode.

## Timing
- Reset values: dec = 0, cur_addr = 0, valid = 0, wrap = 0, state OFF, cnt = 0.
- Latency: inputs sampled at edge k appear on outputs after edge k (one cycle). There is no combinational path from input to output.
- Direct mode: a new addr every cycle gives a new select every cycle (full throughput).
- en deassert: dec = 0 and valid = 0 after the next edge.
- Scan period: (dwell+1) × 2^ADDR_W cycles per full cycle. wrap occurs once per period.
- Simultaneous rst and en: rst wins.
- Simultaneous mode change and dwell expiry: the mode change wins.

## Test plan
- Reset, then en=1, mode=0, addr 0..15 on consecutive cycles → dec = 0x0001, 0x0002, … 0x8000, each one cycle late. Specifically addr=10 → 0x0400 and addr=15 → 0x8000. valid = 1 throughout, and dec is never non-one-hot.
- en=1, mode=1, addr=14, dwell=2 → dec sequence:
  - 0x4000 for 3 cycles;
  - 0x8000 for 3 cycles;
  - 0x0001 with wrap = 1 for its first cycle only;
  - then 0x0002 after 3 more cycles.
- Scanning with dwell=0 → dec advances every cycle. wrap pulses every 16 cycles.
- Mid-scan: change dwell from 200 to 1 while cnt = 50 → idx advances on the next edge, then holds 2 cycles per index.
- Mid-scan: drop mode to 0 with addr=5 → next cycle dec = 0x0020. Raise mode again → scan restarts at 5 with a full dwell.
- Assert rst during scan at idx = 9, and separately rst with en=1 → outputs all zero next cycle. After release, the FSM re-enters per en/mode from cnt = 0.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a dwell-timed auto-scan mode.
// Direct mode decodes addr each cycle; scan mode walks the select from addr upward.
module scan_decoder #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [(1<<ADDR_W)-1:0]   dec,
    output logic [ADDR_W-1:0]        cur_addr,
    output logic                     valid,
    output logic                     wrap
);

    localparam int OUT_W = 1 << ADDR_W;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [ADDR_W-1:0]  next_idx;

    function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // cur_addr doubles as the scan index; it wraps naturally at 2^ADDR_W.
    assign next_idx = cur_addr + ADDR_W'(1);

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            cur_addr <= '0;
            dec      <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
        end else if (!en) begin
            // cur_addr deliberately holds its last value while off.
            state <= OFF;
            cnt   <= '0;
            dec   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state    <= DIRECT;
            cnt      <= '0;
            cur_addr <= addr;
            dec      <= onehot(addr);
            valid    <= 1'b1;
            wrap     <= 1'b0;
        end else if (state != SCAN) begin
            // Scan entry: addr is the start index and is not sampled again.
            state    <= SCAN;
            cnt      <= '0;
            cur_addr <= addr;
            dec      <= onehot(addr);
            valid    <= 1'b1;
            wrap     <= 1'b0;
        end else if (cnt >= dwell) begin
            // >= rather than == so a live drop of dwell below cnt still advances.
            cnt      <= '0;
            cur_addr <= next_idx;
            dec      <= onehot(next_idx);
            valid    <= 1'b1;
            wrap     <= (next_idx == '0);
        end else begin
            cnt  <= cnt + DWELL_W'(1);
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus random stimulus
// compared against a cycle-level behavioural model of the select sequence.
module tb_scan_decoder;

    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 8;
    localparam int N_OUT   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst, en, mode;
    logic [ADDR_W-1:0]   addr;
    logic [DWELL_W-1:0]  dwell;
    logic [N_OUT-1:0]    dec;
    logic [ADDR_W-1:0]   cur_addr;
    logic                valid, wrap;

    int n_vec = 0;
    int n_err = 0;

    // Model state: which index is shown, how many cycles it has been shown,
    // and whether the previous cycle was already scanning.
    int m_idx   = 0;
    int m_shown = 0;
    bit m_scan  = 0;
    bit m_valid = 0;
    bit m_wrap  = 0;

    scan_decoder #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .addr     (addr),
        .dwell    (dwell),
        .dec      (dec),
        .cur_addr (cur_addr),
        .valid    (valid),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        if (rst) begin
            m_idx = 0; m_shown = 0; m_scan = 0; m_valid = 0; m_wrap = 0;
        end else if (!en) begin
            m_scan = 0; m_valid = 0; m_wrap = 0;
        end else if (!mode) begin
            m_scan = 0; m_idx = int'(addr); m_valid = 1; m_wrap = 0;
        end else if (!m_scan) begin
            m_scan = 1; m_idx = int'(addr); m_shown = 1; m_valid = 1; m_wrap = 0;
        end else if (m_shown > int'(dwell)) begin
            m_idx   = (m_idx + 1) % N_OUT;
            m_shown = 1;
            m_wrap  = (m_idx == 0);
        end else begin
            m_shown++;
            m_wrap = 0;
        end
    endtask

    // One clock: update the model, then compare all outputs 1 ns after the edge.
    task automatic step();
        logic [31:0] exp_dec;
        @(posedge clk);
        model_edge();
        #1;
        exp_dec = m_valid ? (32'd1 << m_idx) : 32'd0;
        check("dec",      32'(dec),      exp_dec);
        check("cur_addr", 32'(cur_addr), 32'(m_idx));
        check("valid",    32'(valid),    32'(m_valid));
        check("wrap",     32'(wrap),     32'(m_wrap));
        check("onehot0",  32'($onehot0(dec)), 32'd1);
    endtask

    initial begin
        int wraps;
        int start_idx;
        rst = 1'b1; en = 1'b0; mode = 1'b0; addr = '0; dwell = '0;
        step();
        step();
        check("reset_dec", 32'(dec), 32'd0);
        rst = 1'b0;

        // Direct decode of every address, one per cycle.
        en = 1'b1; mode = 1'b0;
        for (int a = 0; a < N_OUT; a++) begin
            addr = ADDR_W'(a);
            step();
            if (a == 10) check("direct_a10", 32'(dec), 32'h0400);
            if (a == 15) check("direct_a15", 32'(dec), 32'h8000);
        end

        // Scan from 14 with dwell 2 across the wrap.
        addr = 4'd14; dwell = 8'd2; mode = 1'b1;
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wrap) wraps++;
            if (i == 6) check("scan_wrap_first", 32'(dec), 32'h0001);
            if (i == 9) check("scan_after_wrap", 32'(dec), 32'h0002);
        end
        check("scan_wrap_count", 32'(wraps), 32'd1);

        // dwell 0 from index 0: advance every cycle, wrap every 16 cycles.
        en = 1'b0; step();
        en = 1'b1; addr = '0; dwell = '0;
        wraps = 0;
        for (int i = 0; i < 33; i++) begin
            step();
            if (wrap) wraps++;
        end
        check("dwell0_wraps", 32'(wraps), 32'd2);

        // Lower dwell from 200 to 1 while cnt is 50.
        en = 1'b0; step();
        en = 1'b1; addr = 4'd3; dwell = 8'd200;
        for (int i = 0; i < 51; i++) step();
        start_idx = int'(cur_addr);
        dwell = 8'd1;
        step();
        check("dwell_drop_adv", 32'(cur_addr), 32'((start_idx + 1) % N_OUT));
        for (int i = 0; i < 6; i++) step();

        // SCAN -> DIRECT -> SCAN restarts from addr with a full dwell.
        mode = 1'b0; addr = 4'd5;
        step();
        check("to_direct", 32'(dec), 32'h0020);
        mode = 1'b1; dwell = 8'd3;
        for (int i = 0; i < 5; i++) step();
        check("rescan_adv", 32'(cur_addr), 32'd6);

        // Reset mid-scan at index 9, with en held high.
        addr = 4'd9; mode = 1'b0; step();
        mode = 1'b1; dwell = 8'd4; step(); step();
        rst = 1'b1;
        step();
        check("rst_scan_dec", 32'(dec), 32'd0);
        check("rst_scan_idx", 32'(cur_addr), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            addr = ADDR_W'($urandom_range(0, N_OUT - 1));
            if ($urandom_range(0, 15) == 0)
                dwell = ($urandom_range(0, 7) == 0) ? DWELL_W'($urandom_range(0, 255))
                                                    : DWELL_W'($urandom_range(0, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
